// File: rtl/fir_chk_pkg.sv
// fir_chk_pkg: shared state type and width constants for the FIR output checker
package fir_chk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_e;
    localparam int CNT_W = 16;
    localparam int SAMP_W = 11;
endpackage

// File: rtl/fir_out_checker_if.sv
// fir_out_checker_if: expected/filter sample streams plus checker status outputs
interface fir_out_checker_if
    import fir_chk_pkg::*;
#(
    parameter int W = SAMP_W
);
    logic vexp;
    logic [W-1:0] dexp;
    logic exp_rdy;
    logic vout;
    logic [W-1:0] dout;
    logic mismatch;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic ovf;
    logic tmo;
    logic done;
    modport master (
        output vexp, dexp, vout, dout,
        input exp_rdy, mismatch, err_cnt, smp_cnt, ovf, tmo, done
    );
    modport slave (
        input vexp, dexp, vout, dout,
        output exp_rdy, mismatch, err_cnt, smp_cnt, ovf, tmo, done
    );
endinterface

// File: rtl/fir_out_checker_fifo.sv
// chk_fifo: single-clock FIFO holding expected samples until the filter output arrives
module chk_fifo #(
    parameter int W = 11,
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic full_o,
    output logic empty_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic wr_en, rd_en;
    always_comb begin
        rd_en = pop_i && cnt_q != '0;
        wr_en = push_i && (cnt_q != FULL_CNT || rd_en);
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end
    assign head_o = mem_q[rd_q];
    assign full_o = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/fir_out_checker.sv
// fir_out_checker: compares filter output against buffered expected samples.
// Define CHK_TOLERANCE_EN to accept |DOUT - expected| <= TOL instead of exact equality.
module fir_out_checker
    import fir_chk_pkg::*;
#(
    parameter int W = SAMP_W,
    parameter int DEPTH = 8,
    parameter int NSAMP = 1024,
    parameter int TIMEOUT = 256,
    parameter int TOL = 1
) (
    input logic clk_i,
    input logic rst_i,
    fir_out_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] TMO_CNT = SW'(TIMEOUT);
    localparam logic [CNT_W-1:0] NSAMP_CNT = CNT_W'(NSAMP);
    chk_state_e state_q;
    logic [W-1:0] head, exp_val;
    logic full, empty, active, push, pop, drop, under, fail, cmp_ok, fin_d, tmo_d;
    logic [AW:0] cnt, cnt_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] err_q, smp_q, smp_d;
    logic exp_rdy_q, mismatch_q, ovf_q, tmo_q, done_q;

    chk_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push_i(push),
        .pop_i(pop),
        .din_i(bus.dexp),
        .head_o(head),
        .full_o(full),
        .empty_o(empty),
        .cnt_o(cnt)
    );

`ifdef CHK_TOLERANCE_EN
    logic signed [W:0] diff;
    logic [W:0] mag;
    always_comb begin
        diff = $signed({bus.dout[W-1], bus.dout}) - $signed({exp_val[W-1], exp_val});
        mag = diff[W] ? -diff : diff;
        cmp_ok = mag <= (W+1)'(TOL);
    end
`else
    localparam int unused_tol = TOL;
    assign cmp_ok = bus.dout == exp_val;
`endif

    // An empty FIFO with a same-cycle expected sample compares it directly (bypass).
    always_comb begin
        active = state_q != DONE;
        exp_val = empty ? bus.dexp : head;
        push = active && bus.vexp && !(empty && bus.vout) && (!full || bus.vout);
        pop = active && bus.vout && !empty;
        drop = active && bus.vexp && full && !bus.vout;
        under = active && bus.vout && empty && !bus.vexp;
        fail = under || !cmp_ok;
        cnt_d = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        stall_d = (bus.vout || empty) ? '0 : stall_q + 1'b1;
        smp_d = smp_q + {{(CNT_W-1){1'b0}}, active && bus.vout};
        tmo_d = active && stall_d == TMO_CNT;
        fin_d = (active && bus.vout && smp_d == NSAMP_CNT) || tmo_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            stall_q <= '0;
            exp_rdy_q <= 1'b1;
            mismatch_q <= 1'b0;
            err_q <= '0;
            smp_q <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
            done_q <= 1'b0;
        end else if (active) begin
            state_q <= fin_d ? DONE : (state_q == IDLE && !bus.vexp && !bus.vout) ? IDLE : RUN;
            stall_q <= stall_d;
            exp_rdy_q <= !fin_d && cnt_d != FULL_CNT;
            mismatch_q <= bus.vout && fail;
            if (bus.vout && fail && err_q != '1) err_q <= err_q + 1'b1;
            smp_q <= smp_d;
            ovf_q <= ovf_q || drop || under;
            tmo_q <= tmo_q || tmo_d;
            done_q <= fin_d;
        end else begin
            mismatch_q <= 1'b0;
        end
    end

    assign bus.exp_rdy = exp_rdy_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err_cnt = err_q;
    assign bus.smp_cnt = smp_q;
    assign bus.ovf = ovf_q;
    assign bus.tmo = tmo_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_fir_out_checker.sv
// tb_fir_out_checker: directed checks of compare, FIFO boundaries, bypass, timeout and reset
module tb_fir_out_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passes = 0;
    int total = 0;

    fir_out_checker_if #(.W(11)) bus();

    fir_out_checker #(.W(11), .DEPTH(8), .NSAMP(4), .TIMEOUT(16), .TOL(1)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ve, input int de, input logic vo, input int dv);
        bus.vexp = ve;
        bus.dexp = 11'(de);
        bus.vout = vo;
        bus.dout = 11'(dv);
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        total++;
        assert (obs === e) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_exp_rdy"}, bus.exp_rdy, 1);
        chk({tag, "_mismatch"}, bus.mismatch, 0);
        chk({tag, "_err"}, bus.err_cnt, 0);
        chk({tag, "_smp"}, bus.smp_cnt, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
        chk({tag, "_tmo"}, bus.tmo, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        do_reset();
        chk_reset("rst");

        // basic pass: four expected samples, then four matching outputs
        drive(1, 5, 0, 0);
        drive(1, -3, 0, 0);
        drive(1, 100, 0, 0);
        drive(1, -1024, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 5);
        chk("basic1_smp", bus.smp_cnt, 1);
        chk("basic1_mm", bus.mismatch, 0);
        chk("basic1_done", bus.done, 0);
        drive(0, 0, 1, -3);
        chk("basic2_mm", bus.mismatch, 0);
        drive(0, 0, 1, 100);
        chk("basic3_mm", bus.mismatch, 0);
        drive(0, 0, 1, -1024);
        chk("basic4_smp", bus.smp_cnt, 4);
        chk("basic4_err", bus.err_cnt, 0);
        chk("basic4_mm", bus.mismatch, 0);
        chk("basic4_done", bus.done, 1);
        chk("basic4_rdy", bus.exp_rdy, 0);
        drive(0, 0, 1, 0);
        chk("after_done_smp", bus.smp_cnt, 4);
        chk("after_done_ovf", bus.ovf, 0);

        // mismatch: expected 7, filter gives 8
        do_reset();
        drive(1, 7, 0, 0);
        drive(0, 0, 1, 8);
`ifdef CHK_TOLERANCE_EN
        chk("tol8_err", bus.err_cnt, 0);
        chk("tol8_mm", bus.mismatch, 0);
        drive(1, 7, 0, 0);
        drive(0, 0, 1, 9);
        chk("tol9_err", bus.err_cnt, 1);
        chk("tol9_mm", bus.mismatch, 1);
`else
        chk("mm8_err", bus.err_cnt, 1);
        chk("mm8_mm", bus.mismatch, 1);
        drive(0, 0, 0, 0);
        chk("mm8_pulse_end", bus.mismatch, 0);
        drive(1, 7, 0, 0);
        drive(0, 0, 1, 7);
        chk("mm7_err", bus.err_cnt, 1);
        chk("mm7_smp", bus.smp_cnt, 2);
`endif

        // FIFO fill: ready drops after the 8th push, 9th is dropped
        do_reset();
        for (int i = 0; i < 7; i++) drive(1, i, 0, 0);
        chk("fill7_rdy", bus.exp_rdy, 1);
        drive(1, 7, 0, 0);
        chk("fill8_rdy", bus.exp_rdy, 0);
        chk("fill8_ovf", bus.ovf, 0);
        drive(1, 8, 0, 0);
        chk("fill9_ovf", bus.ovf, 1);

        // full FIFO with simultaneous push and pop keeps occupancy at 8
        do_reset();
        for (int i = 10; i < 18; i++) drive(1, i, 0, 0);
        drive(1, 100, 1, 10);
        chk("fullpp_ovf", bus.ovf, 0);
        chk("fullpp_rdy", bus.exp_rdy, 0);
        chk("fullpp_err", bus.err_cnt, 0);
        chk("fullpp_smp", bus.smp_cnt, 1);
        drive(0, 0, 1, 11);
        chk("fullpop_rdy", bus.exp_rdy, 1);
        chk("fullpop_err", bus.err_cnt, 0);

        // empty FIFO, no expected sample: protocol error counted as mismatch
        do_reset();
        drive(0, 0, 1, 5);
        chk("under_ovf", bus.ovf, 1);
        chk("under_err", bus.err_cnt, 1);
        chk("under_mm", bus.mismatch, 1);
        chk("under_smp", bus.smp_cnt, 1);

        // empty FIFO bypass with matching data, sample not stored
        do_reset();
        drive(1, 42, 1, 42);
        chk("byp_err", bus.err_cnt, 0);
        chk("byp_smp", bus.smp_cnt, 1);
        chk("byp_ovf", bus.ovf, 0);
        drive(0, 0, 1, 42);
        chk("byp_not_stored", bus.ovf, 1);

        // timeout 16 cycles after the first push edge
        do_reset();
        drive(1, 1, 0, 0);
        chk("tmo_e0", bus.tmo, 0);
        drive(1, 2, 0, 0);
        for (int i = 2; i < 16; i++) drive(0, 0, 0, 0);
        chk("tmo_e15", bus.tmo, 0);
        chk("tmo_e15_done", bus.done, 0);
        drive(0, 0, 0, 0);
        chk("tmo_e16", bus.tmo, 1);
        chk("tmo_e16_done", bus.done, 1);
        chk("tmo_e16_rdy", bus.exp_rdy, 0);

        // reset wins over same-cycle activity
        rst = 1'b1;
        drive(1, 9, 1, 9);
        rst = 1'b0;
        chk_reset("midrst");

        // new run completes normally
        drive(1, 3, 0, 0);
        drive(0, 0, 1, 3);
        drive(1, -7, 1, -7);
        drive(1, 1023, 1, 1023);
        drive(1, -1024, 1, -1024);
        chk("rerun_smp", bus.smp_cnt, 4);
        chk("rerun_err", bus.err_cnt, 0);
        chk("rerun_done", bus.done, 1);
        chk("rerun_tmo", bus.tmo, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
